frame_buffer_pingpong: RTL and testbench

Parametrised successor to the single-bank capture-to-display frame store. Pixels arrive on a valid-qualified stream and are written into an internal inferred dual-port RAM. A read FSM streams whole frames into the downstream output FIFO under display request and FIFO back-pressure. With DOUBLE_BUF=1, two frame banks are ping-ponged so the display never reads a frame that is still being written (tear-free). Frames that cannot be swapped in are dropped and flagged.

---
 rtl/frame_buffer_pingpong.sv | 172 +++++++++++++++++
 tb/tb_frame_buffer_pingpong.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_pingpong.sv
// Capture-to-display frame store: pixel stream written into an inferred dual-port RAM,
// whole frames streamed out to a FIFO, with optional two-bank ping-pong for tear-free display.
module frame_buffer_pingpong #(
  parameter int DATA_WIDTH   = 12,
  parameter int FRAME_PIXELS = 307200,
  parameter int ADDR_WIDTH   = 19,
  parameter int DOUBLE_BUF   = 1,
  parameter int RD_LATENCY   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_sof,
  output logic                  o_wr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  input  logic                  i_almostfull,
  input  logic                  i_req,
  output logic                  o_wr_bank,
  output logic                  o_rd_bank,
  output logic                  o_frame_done,
  output logic                  o_frame_drop
);

  localparam int DEPTH = (1 + DOUBLE_BUF) * FRAME_PIXELS;
  localparam int PA_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(FRAME_PIXELS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  function automatic logic [PA_W-1:0] phys_addr(input logic bank,
                                                input logic [ADDR_WIDTH-1:0] loc);
    logic [PA_W-1:0] base;
    base = (bank && (DOUBLE_BUF != 0)) ? PA_W'(FRAME_PIXELS) : '0;
    return base + PA_W'(loc);
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] wloc;
  logic                  frame_end;
  logic                  can_swap;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  complete;
  logic [1:0]            drain_cnt;
  logic                  rd_issue;

  // Write side: i_sof forces pixel 0 for the write in the same cycle
  assign wloc      = i_sof ? '0 : waddr;
  assign frame_end = i_valid && (wloc == LAST);
  assign can_swap  = (state == S_IDLE) || (state == S_DONE);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      waddr        <= '0;
      o_frame_done <= 1'b0;
      o_frame_drop <= 1'b0;
      o_wr_bank    <= 1'b0;
      o_rd_bank    <= (DOUBLE_BUF != 0);
    end else begin
      o_frame_done <= frame_end;
      o_frame_drop <= (DOUBLE_BUF != 0) && frame_end && !can_swap;
      if (i_valid) begin
        waddr <= frame_end ? '0 : wloc + 1'b1;
      end else if (i_sof) begin
        waddr <= '0;
      end
      if ((DOUBLE_BUF != 0) && frame_end && can_swap) begin
        o_rd_bank <= o_wr_bank;
        o_wr_bank <= ~o_wr_bank;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_valid) begin
      mem[phys_addr(o_wr_bank, wloc)] <= i_data;
    end
  end

  // Read FSM: reads are only issued in ACTIVE with room downstream
  assign rd_issue = (state == S_ACTIVE) && i_req && !i_almostfull;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= S_IDLE;
      raddr     <= '0;
      complete  <= 1'b0;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          raddr    <= '0;
          complete <= 1'b0;
          if (i_req) state <= S_ACTIVE;
        end
        S_ACTIVE: begin
          drain_cnt <= '0;
          if (!i_req) begin
            state    <= S_DRAIN;
            raddr    <= '0;
            complete <= 1'b0;
          end else if (rd_issue) begin
            if (raddr == LAST) begin
              state    <= S_DRAIN;
              raddr    <= '0;
              complete <= 1'b1;
            end else begin
              raddr <= raddr + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == 2'(RD_LATENCY - 1)) begin
            state <= complete ? S_DONE : S_IDLE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (!i_req) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage p0: RAM array read (read-first against a same-cycle write)
  logic                  vld_p0;
  logic [DATA_WIDTH-1:0] rdata_p0;

  always_ff @(posedge i_clk) begin
    if (rd_issue) begin
      rdata_p0 <= mem[phys_addr(o_rd_bank, raddr)];
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) vld_p0 <= 1'b0;
    else         vld_p0 <= rd_issue;
  end

  generate
    if (RD_LATENCY >= 2) begin : g_lat2
      // Stage p1: RAM output register
      logic                  vld_p1;
      logic [DATA_WIDTH-1:0] rdata_p1;

      always_ff @(posedge i_clk) begin
        rdata_p1 <= rdata_p0;
      end

      always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) vld_p1 <= 1'b0;
        else         vld_p1 <= vld_p0;
      end

      assign o_wr    = vld_p1;
      assign o_wdata = rdata_p1;
    end else begin : g_lat1
      assign o_wr    = vld_p0;
      assign o_wdata = rdata_p0;
    end
  endgenerate

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// Scoreboard bench: a frame-level reference model predicts bank/flag outputs and the
// expected output-FIFO writes for a double-buffered and a single-bank instance.
module tb_frame_buffer_pingpong;
  localparam int DW  = 12;
  localparam int FP  = 64;
  localparam int AW  = 6;
  localparam int LAT = 2;

  localparam int R_IDLE = 0, R_ACT = 1, R_DRAIN = 2, R_DONE = 3;

  logic          clk = 1'b0;
  logic          rstn;
  logic          valid, sof, af, req;
  logic [DW-1:0] data;

  logic          o_wr, o_wr_bank, o_rd_bank, o_frame_done, o_frame_drop;
  logic [DW-1:0] o_wdata;
  logic          s_wr, s_wr_bank, s_rd_bank, s_frame_done, s_frame_drop;
  logic [DW-1:0] s_wdata;

  always #5 clk = ~clk;

  frame_buffer_pingpong #(.DATA_WIDTH(DW), .FRAME_PIXELS(FP), .ADDR_WIDTH(AW),
                          .DOUBLE_BUF(1), .RD_LATENCY(LAT)) u_dut (
    .i_clk(clk), .i_rstn(rstn), .i_valid(valid), .i_data(data), .i_sof(sof),
    .o_wr(o_wr), .o_wdata(o_wdata), .i_almostfull(af), .i_req(req),
    .o_wr_bank(o_wr_bank), .o_rd_bank(o_rd_bank),
    .o_frame_done(o_frame_done), .o_frame_drop(o_frame_drop));

  frame_buffer_pingpong #(.DATA_WIDTH(DW), .FRAME_PIXELS(FP), .ADDR_WIDTH(AW),
                          .DOUBLE_BUF(0), .RD_LATENCY(LAT)) u_dut_sb (
    .i_clk(clk), .i_rstn(rstn), .i_valid(valid), .i_data(data), .i_sof(sof),
    .o_wr(s_wr), .o_wdata(s_wdata), .i_almostfull(af), .i_req(req),
    .o_wr_bank(s_wr_bank), .o_rd_bank(s_rd_bank),
    .o_frame_done(s_frame_done), .o_frame_drop(s_frame_drop));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: two frame banks plus one flat bank for the single-buffer instance
  typedef struct {logic [DW-1:0] d; int due;} exp_t;
  exp_t          q[$];
  exp_t          qs[$];
  logic [DW-1:0] m_mem [2][FP];
  logic [DW-1:0] s_mem [FP];
  int  m_waddr = 0, m_raddr = 0, m_rs = R_IDLE, m_drain_left = 0, cyc = 0;
  bit  m_complete = 0, m_wbank = 0, m_rbank = 1, m_done = 0, m_drop = 0;
  int  drops = 0, s_drops = 0, swaps = 0, wr_count = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_waddr = 0; m_raddr = 0; m_rs = R_IDLE; m_complete = 0;
      m_wbank = 0; m_rbank = 1; m_done = 0; m_drop = 0;
      q.delete(); qs.delete();
    end else begin
      int loc;
      bit fend, issue, may_swap;
      cyc++;
      loc      = sof ? 0 : m_waddr;
      fend     = valid && (loc == FP - 1);
      issue    = (m_rs == R_ACT) && req && !af;
      may_swap = (m_rs == R_IDLE) || (m_rs == R_DONE);
      if (issue) begin
        q.push_back('{m_mem[m_rbank][m_raddr], cyc + LAT - 1});
        qs.push_back('{s_mem[m_raddr], cyc + LAT - 1});
      end
      if (m_rs == R_IDLE) begin
        m_raddr = 0;
        if (req) m_rs = R_ACT;
      end else if (m_rs == R_ACT) begin
        if (!req) begin
          m_rs = R_DRAIN; m_drain_left = LAT; m_complete = 0; m_raddr = 0;
        end else if (issue) begin
          m_raddr++;
          if (m_raddr == FP) begin
            m_rs = R_DRAIN; m_drain_left = LAT; m_complete = 1; m_raddr = 0;
          end
        end
      end else if (m_rs == R_DRAIN) begin
        m_drain_left--;
        if (m_drain_left == 0) m_rs = m_complete ? R_DONE : R_IDLE;
      end else begin
        if (!req) m_rs = R_IDLE;
      end
      if (valid) begin
        m_mem[m_wbank][loc] = data;
        s_mem[loc] = data;
        m_waddr = (loc + 1) % FP;
      end else if (sof) begin
        m_waddr = 0;
      end
      m_done = fend;
      m_drop = fend && !may_swap;
      if (fend && may_swap) begin
        m_rbank = m_wbank;
        m_wbank = !m_wbank;
        swaps++;
      end
    end
  end

  // Monitor: compares every output each cycle and pops the scoreboard on FIFO writes
  always @(negedge clk) begin
    exp_t e;
    check("wr_bank", o_wr_bank, m_wbank);
    check("rd_bank", o_rd_bank, m_rbank);
    check("frame_done", o_frame_done, m_done);
    check("frame_drop", o_frame_drop, m_drop);
    check("sb_wr_bank", s_wr_bank, 0);
    check("sb_rd_bank", s_rd_bank, 0);
    check("sb_frame_done", s_frame_done, m_done);
    check("sb_frame_drop", s_frame_drop, 0);
    if (o_frame_drop) drops++;
    if (s_frame_drop) s_drops++;
    if (o_wr) begin
      wr_count++;
      if (q.size() == 0) check("wr_spurious", o_wr, 0);
      else begin
        e = q.pop_front();
        check("wdata", o_wdata, e.d);
        check("wr_time", cyc, e.due);
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      check("wr_missing", o_wr, 1);
      void'(q.pop_front());
    end
    if (s_wr) begin
      if (qs.size() == 0) check("sb_wr_spurious", s_wr, 0);
      else begin
        e = qs.pop_front();
        check("sb_wdata", s_wdata, e.d);
        check("sb_wr_time", cyc, e.due);
      end
    end else if (qs.size() > 0 && qs[0].due <= cyc) begin
      check("sb_wr_missing", s_wr, 1);
      void'(qs.pop_front());
    end
  end

  task automatic write_frame(input bit af_pattern);
    for (int i = 0; i < FP; i++) begin
      @(negedge clk);
      valid = 1'b1;
      sof   = (i == 0);
      data  = DW'($urandom);
      if (af_pattern) af = ((i % 20) < 5);
    end
    @(negedge clk);
    valid = 1'b0;
    sof   = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int d0, w0;
    bit seen;
    rstn = 1'b0; valid = 1'b0; sof = 1'b0; af = 1'b0; req = 1'b0; data = '0;
    idle_cycles(3);
    check("reset_wr", o_wr, 0);
    check("reset_rd_bank", o_rd_bank, 1);
    rstn = 1'b1;

    // Case 1: first frame with the display idle, data = pixel index
    for (int i = 0; i < FP; i++) begin
      @(negedge clk);
      valid = 1'b1; sof = (i == 0); data = DW'(i);
    end
    @(negedge clk);
    valid = 1'b0; sof = 1'b0;
    check("c1_wr_bank", o_wr_bank, 1);
    check("c1_rd_bank", o_rd_bank, 0);
    check("c1_drops", drops, 0);

    // Case 2: full read of the swapped-in frame
    w0 = wr_count;
    req = 1'b1;
    idle_cycles(FP + 10);
    check("c2_wr_count", wr_count - w0, FP);
    req = 1'b0;
    idle_cycles(3);

    // Cases 3/4: back-pressure pattern while a frame completes during ACTIVE -> drop
    d0 = drops;
    req = 1'b1;
    write_frame(1'b1);
    check("c4_drop_wr_bank", o_wr_bank, 1);
    check("c4_drop_rd_bank", o_rd_bank, 0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      af = ((i % 20) < 5);
    end
    af = 1'b0;
    check("c4_drop_count", drops - d0, 1);
    write_frame(1'b0);
    check("c4_swap_wr_bank", o_wr_bank, 0);
    check("c4_swap_rd_bank", o_rd_bank, 1);

    // Case 5: abort mid-frame, then restart from pixel 0
    req = 1'b0;
    idle_cycles(2);
    req = 1'b1;
    idle_cycles(12);
    req = 1'b0;
    w0 = wr_count;
    idle_cycles(8);
    check("c5_abort_tail", (wr_count - w0) <= LAT, 1);
    req = 1'b1;
    idle_cycles(FP + 10);
    req = 1'b0;
    idle_cycles(4);

    // Randomised traffic: gaps, stray sof, back-pressure and request toggling
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      valid = ($urandom_range(0, 3) != 0);
      sof   = ($urandom_range(0, 199) == 0);
      data  = DW'($urandom);
      af    = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 99) == 0) req = ~req;
    end
    valid = 1'b0; sof = 1'b0; af = 1'b0;

    // Case 6: async reset while o_wr is high
    req = 1'b0;
    idle_cycles(LAT + 4);
    req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = o_wr;
    end
    check("c6_wait_owr", seen, 1);
    #2 rstn = 1'b0;
    #1;
    check("c6_rst_wr", o_wr, 0);
    check("c6_rst_wr_bank", o_wr_bank, 0);
    check("c6_rst_rd_bank", o_rd_bank, 1);
    check("c6_rst_done", o_frame_done, 0);
    check("c6_rst_drop", o_frame_drop, 0);
    check("c6_rst_sb_wr", s_wr, 0);
    req = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    idle_cycles(LAT + 2);
    check("c6_no_wr_after_rst", o_wr, 0);

    // Repeat of case 1 after reset: single-bank instance never swaps or drops
    write_frame(1'b0);
    check("c6_wr_bank", o_wr_bank, 1);
    check("c6_sb_wr_bank", s_wr_bank, 0);
    check("c6_sb_rd_bank", s_rd_bank, 0);
    req = 1'b1;
    idle_cycles(FP + 10);
    req = 1'b0;
    idle_cycles(4);
    check("sb_drop_total", s_drops, 0);
    check("swaps_seen", swaps > 3, 1);
    check("scoreboard_empty", q.size() + qs.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
